reverse_index_gen: RTL
======================

REVERSE_INDEX_GEN -- requirements
Module: reverse_index_gen

Interface
REQ-001 Parameter ROWS, default 4, number of rows; SHALL be >= 1.
REQ-002 Parameter COLS, default 4, number of columns; SHALL be >= 1.
REQ-003 Parameter UPPER_TRI, default 0; when 1, only upper-triangular entries are emitted; SHALL require ROWS == COLS.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  begin a sweep; sampled only in IDLE.
REQ-007 abort  input  1  terminate the sweep; return to IDLE.
REQ-008 out_valid  output  1  row/col/last are valid.
REQ-009 out_ready  input  1  consumer accepts the current index.
REQ-010 row  output  $clog2(ROWS) (min 1)  current row index.
REQ-011 col  output  $clog2(COLS) (min 1)  current column index.
REQ-012 last  output  1  the current index is the final one of the sweep.
REQ-013 busy  output  1  high in RUN.
REQ-014 done  output  1  one-cycle pulse after the final handshake.

Function
REQ-015 The FSM SHALL have the states IDLE, RUN, and DONE.
REQ-016 In IDLE with start=1, the next state SHALL be RUN with row=ROWS-1 and col=COLS-1.
REQ-017 out_valid SHALL equal (state==RUN); busy SHALL equal out_valid.
REQ-018 A transfer SHALL occur when out_valid && out_ready; without a transfer, row/col/last SHALL hold.
REQ-019 On a transfer, col SHALL decrement; at col==col_min, col SHALL reload to COLS-1 and row SHALL decrement.
REQ-020 col_min SHALL be 0 when UPPER_TRI=0 and the current row when UPPER_TRI=1.
REQ-021 last SHALL be (row==0 && col==col_min) in RUN, and 0 otherwise.
REQ-022 A transfer with last=1 SHALL move the FSM to DONE; DONE SHALL assert done for exactly one cycle and then move to IDLE.
REQ-023 Transfers per sweep SHALL be ROWS*COLS, or N*(N+1)/2 when UPPER_TRI=1.
REQ-024 The first valid index SHALL appear one cycle after start is sampled.
REQ-025 Back-to-back transfers SHALL sustain one per cycle.
REQ-026 start SHALL be ignored in RUN and DONE.
REQ-027 abort SHALL take priority over transfer and start in every state: next state IDLE, no done pulse.
REQ-028 A ROWS=COLS=1 sweep SHALL emit a single index (0,0) with last=1.
REQ-029 Index arithmetic SHALL never underflow; wrap occurs only via the reload rules above.

Reset
REQ-030 Reset SHALL force state=IDLE, row=0, col=0, out_valid=0, last=0, busy=0, done=0.
REQ-031 Reset asserted mid-sweep SHALL discard the sweep; after release, the block SHALL wait for a new start.

Structure
REQ-032 The FSM state enum SHALL reside in the shared package lcmv_pkg as index_gen_state_t.
REQ-033 The column counter SHALL be a sub-module counter_down_load with ports clk, rst, load, load_val, down, min_val, min_hit, out.
REQ-034 row SHALL decrement on col min_hit && transfer.

Verification
REQ-035 ROWS=2, COLS=3, out_ready=1, start pulse -> (1,2),(1,1),(1,0),(0,2),(0,1),(0,0) on consecutive cycles, last on (0,0), done one cycle later.
REQ-036 UPPER_TRI=1, N=3 -> (2,2),(1,2),(1,1),(0,2),(0,1),(0,0); 6 transfers.
REQ-037 Random out_ready stalls -> indices held stable while out_valid && !out_ready; sequence identical to REQ-035.
REQ-038 abort at the third index -> out_valid=0 next cycle, no done; a new start restarts at (ROWS-1, COLS-1).
REQ-039 rst asserted mid-sweep with clk stopped -> outputs reach reset values immediately; a later start runs a full sweep.
REQ-040 ROWS=COLS=1 -> single (0,0) with last=1; done follows; start during RUN and DONE is ignored.

Source files
------------

// File: rtl/lcmv_pkg.sv
// Shared types and helpers for the index-generator slice: the sweep FSM
// state encoding and the index-width rule used for row/column buses.
package lcmv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } index_gen_state_t;

  // A dimension of size 1 still needs a one-bit index bus.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/counter_down_load.sv
// Loadable down-counter with a programmable floor; reaching the floor on a
// down step reloads the counter instead of wrapping through zero.
module counter_down_load #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         down,
  input  logic [W-1:0] min_val,
  output logic         min_hit,
  output logic [W-1:0] out
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign min_hit = (cnt_q == min_val);
  assign out     = cnt_q;

  // Next count: load wins over down; a step at the floor reloads.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (down) begin
      if (min_hit) begin
        cnt_d = load_val;
      end else begin
        cnt_d = cnt_q - W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reverse_index_gen.sv
// Emits (row, col) index pairs in reverse raster order over a ROWS x COLS
// grid, optionally restricted to the upper triangle, with valid/ready flow.
module reverse_index_gen
  import lcmv_pkg::*;
#(
  parameter int unsigned ROWS      = 4,
  parameter int unsigned COLS      = 4,
  parameter bit          UPPER_TRI = 1'b0,
  localparam int unsigned RW       = idx_width(ROWS),
  localparam int unsigned CW       = idx_width(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last,
  output logic          busy,
  output logic          done
);

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  if (ROWS < 1 || COLS < 1) begin : g_bad_dims
    $error("reverse_index_gen: ROWS and COLS must be at least 1");
  end
  if (UPPER_TRI && (ROWS != COLS)) begin : g_bad_tri
    $error("reverse_index_gen: UPPER_TRI requires ROWS == COLS");
  end

  index_gen_state_t state_q;
  index_gen_state_t state_d;
  logic [RW-1:0]    row_q;
  logic [RW-1:0]    row_d;
  logic [CW-1:0]    col_cnt;
  logic [CW-1:0]    col_min;
  logic             col_hit;
  logic             col_load;
  logic             col_down;
  logic             run;
  logic             xfer;
  logic             last_idx;

  // In the triangular sweep a row ends on the diagonal.
  assign col_min  = UPPER_TRI ? CW'(row_q) : '0;
  assign run      = (state_q == ST_RUN);
  assign xfer     = run && out_ready;
  assign last_idx = run && (row_q == '0) && col_hit;

  assign out_valid = run;
  assign busy      = run;
  assign done      = (state_q == ST_DONE);
  assign last      = last_idx;
  assign row       = row_q;
  assign col       = col_cnt;

  counter_down_load #(
    .W (CW)
  ) u_col (
    .clk      (clk),
    .rst      (rst),
    .load     (col_load),
    .load_val (COL_MAX),
    .down     (col_down),
    .min_val  (col_min),
    .min_hit  (col_hit),
    .out      (col_cnt)
  );

  // Sweep control: abort dominates; the final transfer leaves indices at
  // (0, col_min) rather than stepping past them.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_load = 1'b0;
    col_down = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d  = ST_RUN;
          row_d    = ROW_MAX;
          col_load = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (xfer) begin
          if (last_idx) begin
            state_d = ST_DONE;
          end else begin
            col_down = 1'b1;
            if (col_hit) begin
              row_d = row_q - RW'(1);
            end else begin
              row_d = row_q;
            end
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and row registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

endmodule
